plinko_board_pipe: RTL

Parametrised, pipelined successor to the single-cycle Plinko board. Accepts one ball per cycle through a valid/ready drop port. Each ball descends one peg row per clock, driven by a ROWS-bit path word. It lands in one of ROWS+1 bins, each with a saturating hit counter. Sits between the random-path source and the histogram display/readout logic.

---
 rtl/plinko_board_pipe.sv | 131 +++++++++++++
 1 files changed

// File: rtl/plinko_board_pipe.sv
// plinko_board_pipe
//
// Pipelined Plinko board. Balls are offered on a valid/ready drop port, and
// the board can accept one per clock. Each ball falls one peg row per clock.
// Row k moves the ball one bin to the right when path bit k is 1.
// After ROWS rows the ball lands in bin popcount(path), in the range 0..ROWS.
// Each bin has a saturating hit counter, and a saturating total counts every
// ball that lands.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset; discards balls in flight
//   drop_valid   a ball is offered this cycle
//   drop_path    ROWS-bit path word (bit k=1: right at row k)
//   drop_ready   board accepts the offered ball (= !hold, combinational)
//   hold         stop accepting new balls; balls in flight keep falling
//   clear        synchronous clear of all bin counters and total_count
//   counts       flattened bin counters, bin b at [b*CNT_W +: CNT_W]
//   total_count  saturating count of landed balls
//   land_valid   one-cycle pulse per landed ball
//   land_bin     bin of the ball flagged by land_valid
//   busy         at least one ball is in flight

module plinko_board_pipe #(
    parameter int ROWS  = 7,
    parameter int CNT_W = 5,
    parameter int TOT_W = 8,
    localparam int BIN_W = $clog2(ROWS + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      drop_valid,
    input  logic [ROWS-1:0]           drop_path,
    output logic                      drop_ready,
    input  logic                      hold,
    input  logic                      clear,
    output logic [(ROWS+1)*CNT_W-1:0] counts,
    output logic [TOT_W-1:0]          total_count,
    output logic                      land_valid,
    output logic [BIN_W-1:0]          land_bin,
    output logic                      busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [TOT_W-1:0] TOT_MAX = {TOT_W{1'b1}};

    // Per-stage ball state. Stage k has already applied path bits 0..k.
    // The next unused path bit always sits at rem[0].
    logic [ROWS-1:0]  stg_valid;
    logic [BIN_W-1:0] stg_pos [ROWS];
    logic [ROWS-1:0]  stg_rem [ROWS];

    logic [CNT_W-1:0] cnt [ROWS+1];

    logic accept;
    logic landing;

    assign drop_ready = !hold;
    assign accept     = drop_valid && drop_ready;
    assign landing    = stg_valid[ROWS-1];
    assign busy       = |stg_valid;

    always_comb begin
        counts = '0;
        for (int b = 0; b <= ROWS; b++) begin
            counts[b*CNT_W +: CNT_W] = cnt[b];
        end
    end

    // The falling pipeline. Stage 0 takes the accepted ball and applies
    // path bit 0 on the acceptance edge. Every stage then advances each
    // clock. Held or idle inputs enter the pipeline as invalid bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid <= '0;
            for (int k = 0; k < ROWS; k++) begin
                stg_pos[k] <= '0;
                stg_rem[k] <= '0;
            end
        end else begin
            stg_valid[0] <= accept;
            stg_pos[0]   <= BIN_W'(drop_path[0]);
            stg_rem[0]   <= drop_path >> 1;
            for (int k = 1; k < ROWS; k++) begin
                stg_valid[k] <= stg_valid[k-1];
                stg_pos[k]   <= stg_pos[k-1] + BIN_W'(stg_rem[k-1][0]);
                stg_rem[k]   <= stg_rem[k-1] >> 1;
            end
        end
    end

    // Landing report. land_bin keeps the last landed bin between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            land_valid <= 1'b0;
            land_bin   <= '0;
        end else begin
            land_valid <= landing;
            if (landing) begin
                land_bin <= stg_pos[ROWS-1];
            end
        end
    end

    // Hit counters. If clear and a landing occur on the same edge, clear
    // wins and the landing is not counted. The landing is still reported
    // on land_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_count <= '0;
            for (int b = 0; b <= ROWS; b++) begin
                cnt[b] <= '0;
            end
        end else if (clear) begin
            total_count <= '0;
            for (int b = 0; b <= ROWS; b++) begin
                cnt[b] <= '0;
            end
        end else if (landing) begin
            if (total_count != TOT_MAX) begin
                total_count <= total_count + TOT_W'(1);
            end
            for (int b = 0; b <= ROWS; b++) begin
                if (stg_pos[ROWS-1] == BIN_W'(b) && cnt[b] != CNT_MAX) begin
                    cnt[b] <= cnt[b] + CNT_W'(1);
                end
            end
        end
    end

endmodule
